// File: rtl/io_parallel_out.sv
// Parallel output port in I/O space: buffers one processor-written byte and hands
// it to an external consumer over a four-phase dav_/rfd handshake.
module io_parallel_out #(
    parameter logic [15:0] BASE_ADDR   = 16'h0040,
    parameter int          IO_SIZE     = 16,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset_switch,
    input  logic [IO_SIZE-1:0] addr,
    inout  wire  [7:0]         d7_d0,
    input  logic               ior_,
    input  logic               iow_,
    output logic [7:0]         byte_out,
    output logic               dav_,
    input  logic               rfd,
    output logic               intr
);

    localparam logic [IO_SIZE-1:0] STS_ADDR  = IO_SIZE'(BASE_ADDR);
    localparam logic [IO_SIZE-1:0] DATA_ADDR = IO_SIZE'(BASE_ADDR + 16'd1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RFD = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             tbr_q, tbr_d;
    logic                   fo_q, fo_d;
    logic                   ie_q, ie_d;
    logic                   ovr_q, ovr_d;
    logic                   dav_n_q, dav_n_d;
    logic                   intr_q, intr_d;
    logic                   iow_q, ior_q;
    logic [SYNC_STAGES-1:0] rfd_sync_q, rfd_sync_d;

    logic       rfd_s;
    logic       sel_sts, sel_data;
    logic       sts_wr, data_wr, sts_rd;
    logic [7:0] sts;

    // rfd comes from another clock domain; stage 0 may go metastable.
    assign rfd_sync_d[0] = rfd;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_rfd_sync
            assign rfd_sync_d[gi] = rfd_sync_q[gi-1];
        end
    endgenerate
    assign rfd_s = rfd_sync_q[SYNC_STAGES-1];

    assign sel_sts  = (addr == STS_ADDR);
    assign sel_data = (addr == DATA_ADDR);

    // One event per strobe: only the falling edge of the sampled strobe counts.
    assign sts_wr  = iow_q & ~iow_ & sel_sts;
    assign data_wr = iow_q & ~iow_ & sel_data;
    assign sts_rd  = ior_q & ~ior_ & sel_sts;

    assign sts = {5'b00000, ovr_q, ie_q, fo_q};

    assign d7_d0 = (!ior_ && sel_sts)  ? sts   :
                   (!ior_ && sel_data) ? tbr_q : 8'hzz;

    assign byte_out = tbr_q;
    assign dav_     = dav_n_q;
    assign intr     = intr_q;

    always_comb begin
        state_d = state_q;
        tbr_d   = tbr_q;
        fo_d    = fo_q;
        ie_d    = ie_q;
        ovr_d   = ovr_q;
        dav_n_d = dav_n_q;
        intr_d  = ie_q & fo_q;

        if (sts_wr)
            ie_d = d7_d0[1];
        if (sts_rd)
            ovr_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_wr && fo_q) begin
                    tbr_d   = d7_d0;
                    fo_d    = 1'b0;
                    state_d = WAIT_RFD;
                end
            end
            WAIT_RFD: begin
                if (rfd_s) begin
                    dav_n_d = 1'b0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!rfd_s) begin
                    dav_n_d = 1'b1;
                    fo_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                dav_n_d = 1'b1;
                fo_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        // Decided on the pre-edge FO, so it also catches a write racing the release.
        if (data_wr && !fo_q)
            ovr_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset_switch) begin
        if (reset_switch) begin
            state_q    <= IDLE;
            tbr_q      <= 8'h00;
            fo_q       <= 1'b1;
            ie_q       <= 1'b0;
            ovr_q      <= 1'b0;
            dav_n_q    <= 1'b1;
            intr_q     <= 1'b0;
            iow_q      <= 1'b1;
            ior_q      <= 1'b1;
            rfd_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            tbr_q      <= tbr_d;
            fo_q       <= fo_d;
            ie_q       <= ie_d;
            ovr_q      <= ovr_d;
            dav_n_q    <= dav_n_d;
            intr_q     <= intr_d;
            iow_q      <= iow_;
            ior_q      <= ior_;
            rfd_sync_q <= rfd_sync_d;
        end
    end

endmodule

// File: tb/tb_io_parallel_out.sv
// Directed bench for io_parallel_out: bus reads/writes, handshake timing,
// overrun, interrupt, strobe decoding and mid-handshake reset.
module tb_io_parallel_out;

    logic        clock = 1'b0;
    logic        reset_switch = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        ior_ = 1'b1;
    logic        iow_ = 1'b1;
    logic        rfd = 1'b0;
    logic        tb_drive = 1'b0;
    logic [7:0]  tb_data = 8'h00;
    wire  [7:0]  d7_d0;
    logic [7:0]  byte_out;
    logic        dav_;
    logic        intr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rd_val;

    assign d7_d0 = tb_drive ? tb_data : 8'hzz;

    io_parallel_out #(
        .BASE_ADDR  (16'h0040),
        .IO_SIZE    (16),
        .SYNC_STAGES(2)
    ) dut (
        .clock       (clock),
        .reset_switch(reset_switch),
        .addr        (addr),
        .d7_d0       (d7_d0),
        .ior_        (ior_),
        .iow_        (iow_),
        .byte_out    (byte_out),
        .dav_        (dav_),
        .rfd         (rfd),
        .intr        (intr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Each bus task idles one negedge first, so back-to-back calls give distinct strobes.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        addr = a; tb_data = d; tb_drive = 1'b1; iow_ = 1'b0;
        @(posedge clock);
        @(negedge clock);
        iow_ = 1'b1; tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clock);
        addr = a; ior_ = 1'b0;
        #1 d = d7_d0;
        @(posedge clock);
        @(negedge clock);
        ior_ = 1'b1;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state; bench drives the bus to show the DUT leaves it alone.
        wait_neg(3);
        check("reset_dav", {7'd0, dav_}, 8'h01);
        check("reset_intr", {7'd0, intr}, 8'h00);
        check("reset_byte_out", byte_out, 8'h00);
        tb_data = 8'h5A; tb_drive = 1'b1;
        #1 check("reset_bus_free", d7_d0, 8'h5A);
        tb_drive = 1'b0;
        reset_switch = 1'b0;
        bus_read(16'h0040, rd_val);
        check("reset_sts", rd_val, 8'h01);

        // Basic transfer with rfd already high and synchronized.
        rfd = 1'b1;
        wait_neg(3);
        bus_write(16'h0041, 8'hA5);
        check("basic_byte_out", byte_out, 8'hA5);
        check("basic_dav_before", {7'd0, dav_}, 8'h01);
        wait_neg(1);
        check("basic_dav_fall", {7'd0, dav_}, 8'h00);
        bus_read(16'h0040, rd_val);
        check("basic_sts_busy", rd_val, 8'h00);
        rfd = 1'b0;
        wait_neg(2);
        check("basic_dav_hold", {7'd0, dav_}, 8'h00);
        wait_neg(1);
        check("basic_dav_release", {7'd0, dav_}, 8'h01);
        bus_read(16'h0040, rd_val);
        check("basic_sts_free", rd_val, 8'h01);

        // Overrun: second write finds the buffer occupied.
        bus_write(16'h0041, 8'h11);
        bus_write(16'h0041, 8'h22);
        check("ovr_byte_out", byte_out, 8'h11);
        bus_read(16'h0040, rd_val);
        check("ovr_sts", rd_val, 8'h04);
        bus_read(16'h0040, rd_val);
        check("ovr_cleared", rd_val, 8'h00);
        bus_read(16'h0041, rd_val);
        check("ovr_tbr_read", rd_val, 8'h11);
        rfd = 1'b1;
        wait_neg(4);
        check("ovr_dav_fall", {7'd0, dav_}, 8'h00);
        rfd = 1'b0;
        wait_neg(4);
        bus_read(16'h0040, rd_val);
        check("ovr_sts_free", rd_val, 8'h01);

        // Interrupt enable, busy and release.
        bus_write(16'h0040, 8'h02);
        check("intr_not_yet", {7'd0, intr}, 8'h00);
        wait_neg(1);
        check("intr_enabled", {7'd0, intr}, 8'h01);
        bus_write(16'h0041, 8'h77);
        check("intr_still_high", {7'd0, intr}, 8'h01);
        wait_neg(1);
        check("intr_busy_low", {7'd0, intr}, 8'h00);
        rfd = 1'b1;
        wait_neg(3);
        check("intr_dav_fall", {7'd0, dav_}, 8'h00);
        rfd = 1'b0;
        wait_neg(3);
        check("intr_dav_release", {7'd0, dav_}, 8'h01);
        check("intr_lags_fo", {7'd0, intr}, 8'h00);
        wait_neg(1);
        check("intr_after_release", {7'd0, intr}, 8'h01);
        bus_read(16'h0040, rd_val);
        check("intr_sts", rd_val, 8'h03);

        // Long write strobe produces one load, no overrun.
        @(negedge clock);
        addr = 16'h0041; tb_data = 8'h33; tb_drive = 1'b1; iow_ = 1'b0;
        wait_neg(10);
        iow_ = 1'b1; tb_drive = 1'b0;
        check("long_byte_out", byte_out, 8'h33);
        bus_read(16'h0040, rd_val);
        check("long_sts", rd_val, 8'h02);

        // Unmapped address: no write effect, bus not driven on read.
        bus_write(16'h0042, 8'h99);
        check("decode_byte_out", byte_out, 8'h33);
        bus_read(16'h0040, rd_val);
        check("decode_sts", rd_val, 8'h02);
        @(negedge clock);
        addr = 16'h0042; tb_data = 8'h5A; tb_drive = 1'b1; ior_ = 1'b0;
        #1 check("decode_bus_free", d7_d0, 8'h5A);
        @(negedge clock);
        ior_ = 1'b1; tb_drive = 1'b0;

        // Reset in WAIT_ACK drops dav_ without waiting for a clock.
        rfd = 1'b1;
        wait_neg(4);
        check("rst_dav_low", {7'd0, dav_}, 8'h00);
        #2 reset_switch = 1'b1;
        #1 check("rst_dav_async", {7'd0, dav_}, 8'h01);
        check("rst_byte_out", byte_out, 8'h00);
        rfd = 1'b0;
        wait_neg(2);
        reset_switch = 1'b0;
        bus_read(16'h0040, rd_val);
        check("rst_sts", rd_val, 8'h01);
        bus_write(16'h0041, 8'h5C);
        check("rst_next_byte", byte_out, 8'h5C);
        bus_read(16'h0040, rd_val);
        check("rst_next_sts", rd_val, 8'h00);
        check("rst_intr", {7'd0, intr}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_parallel_out.md
# io_parallel_out

- Parallel output interface that sits in the I/O space and responds to processor bus cycles on `addr`, `d7_d0`, `ior_` and `iow_`.
- Buffers one byte written by the processor and hands it to an external consumer over a four-phase `dav_`/`rfd` handshake.
- Exposes a status/control port and an optional interrupt request.
- It is instantiated inside `io_space` next to the other port devices.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0040: status/control port address; the data port is at `BASE_ADDR+1`.
- `IO_SIZE`, 16: I/O address width.
- `SYNC_STAGES`, 2: number of flip-flop stages on `rfd` (minimum 2).

Ports:
- `clock`  in  1: system clock; all state changes on the rising edge.
- `reset_switch`  in  1: reset, asynchronous, active-high.
- `addr`  in  IO_SIZE: I/O port address from the processor.
- `d7_d0`  inout  8: data bus; driven only during a matching read, otherwise Z.
- `ior_`  in  1: I/O read strobe, active-low.
- `iow_`  in  1: I/O write strobe, active-low.
- `byte_out`  out  8: byte presented to the consumer (TBR contents).
- `dav_`  out  1: data valid, active-low.
- `rfd`  in  1: consumer ready for data, active-high, asynchronous to `clock`.
- `intr`  out  1: interrupt request, active-high.

## Operation
Registers:
- TBR[7:0]: data buffer.
- STS: bit0 FO (buffer free), bit1 IE (interrupt enable), bit2 OVR (overrun). Bits 7:3 read as 0.

Bus reads:
- Combinational: `d7_d0` = STS when `ior_`=0 and `addr`=BASE_ADDR.
- `d7_d0` = TBR when `ior_`=0 and `addr`=BASE_ADDR+1.
- Otherwise `d7_d0` is Z.

Strobe detection:
- `iow_` and `ior_` are sampled every edge into `iow_q` and `ior_q` (reset value 1).
- A write event is `iow_q`=1 and `iow_`=0, with `addr` matching at that edge. A read event is defined the same way on `ior_`.
- Holding a strobe low for many cycles produces exactly one event.

Write to BASE_ADDR:
- IE <= `d7_d0`[1]. Other bits are ignored.

Write to BASE_ADDR+1:
- If FO=1: TBR <= `d7_d0`, FO <= 0, FSM goes IDLE->WAIT_RFD.
- If FO=0: TBR is unchanged and OVR <= 1.

Read event at BASE_ADDR:
- Clears OVR. If an overrun occurs at the same edge, set wins.

Handshake FSM (`rfd_s` is `rfd` after SYNC_STAGES flops):
- IDLE: `dav_`=1, FO=1. Leaves only on an accepted data write.
- WAIT_RFD: if `rfd_s`=1, drive `dav_` <= 0 and go to WAIT_ACK.
- WAIT_ACK: if `rfd_s`=0, drive `dav_` <= 1, FO <= 1 and go to IDLE.

Outputs:
- `byte_out` = TBR at all times.
- `intr` = IE & FO, registered.

Simultaneous events:
- A data write at the same edge where WAIT_ACK completes sees FO=0 (the pre-edge value). It is treated as an overrun.

## Timing
- Reset (async, while `reset_switch`=1):
  - `dav_`=1, `byte_out`=0, TBR=0, FO=1, IE=0, OVR=0, `intr`=0, state IDLE.
  - `d7_d0`=Z, `iow_q`=`ior_q`=1, sync flops=0.
- Reset asserted mid-handshake immediately returns `dav_` to 1. The byte is discarded.
- Data write event at edge N: TBR and FO=0 valid after N; `intr` falls after N+1.
- `rfd` rising between edges M-1 and M: `rfd_s`=1 after edge M+SYNC_STAGES-1, and `dav_` falls at the following edge.
  - If `rfd` was already 1 and synchronized, `dav_` falls at edge N+1.
- Release: `rfd` falling gives `dav_`=1 and FO=1 after SYNC_STAGES+1 edges. `intr` follows one edge later if IE=1.
- The consumer must not deassert `rfd` before seeing `dav_`=0. It must sample `byte_out` while `dav_`=0.
- Bus reads require no wait states. Data is valid `addr`/`ior_` propagation time after the strobe falls.

## Test plan
- Reset:
  - Assert `reset_switch` -> `dav_`=1, `intr`=0, `d7_d0`=Z.
  - Read BASE_ADDR -> 8'h01.
- Basic transfer:
  - Stimulus: `rfd`=1; write 8'hA5 to 16'h0041.
  - Required: `byte_out`=8'hA5; `dav_` falls 1 edge later; STS reads 8'h00.
  - Then drop `rfd` -> `dav_`=1 after 3 edges; STS reads 8'h01.
- Overrun:
  - Stimulus: `rfd`=0; write 8'h11 then 8'h22.
  - Required: TBR=8'h11; STS=8'h04.
  - Then read STS again -> 8'h00 (OVR cleared by the first read).
- Interrupt:
  - Write 8'h02 to BASE_ADDR -> `intr`=1.
  - Write data -> `intr`=0.
  - Complete the handshake -> `intr`=1 one edge after FO.
- Long strobe and decode:
  - Hold `iow_` low for 10 cycles with 8'h33 -> exactly one load, no OVR.
  - Write to 16'h0042 -> no effect; `d7_d0` stays Z on reads of 16'h0042.
- Reset mid-handshake:
  - Assert reset while in WAIT_ACK -> `dav_`=1 asynchronously, STS=8'h01.
  - The next write is accepted normally.
